mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multicycle control unit for the 32-bit MIPS-subset CPU.
//  Sequences the shared datapath (PC, IR, reg file, ALU, unified memory) through IF/ID/EXE/MEM/WB.
//  Drives every register write enable and mux select. Waits on a memory-ready handshake.
//  Sits between the IR/op decode and the dff-based datapath registers.
// PARAMETERS
//  MEM_WAIT  1  1: IF/MEM stall until mready=1; 0: mready ignored, treated as 1
// PORTS
//  clk       in   1  system clock, all state updates on rising edge
//  clrn      in   1  asynchronous active-low reset
//  op        in   6  IR[31:26]
//  func      in   6  IR[5:0]
//  z         in   1  ALU zero flag (valid in EXE)
//  mready    in   1  memory access complete this cycle
//  wpc       out  1  PC write enable
//  wir       out  1  IR write enable
//  wmem      out  1  memory write enable
//  wreg      out  1  register-file write enable
//  iord      out  1  memory address mux: 0=PC, 1=ALU result reg
//  regrt     out  1  dest reg: 0=rd, 1=rt
//  m2reg     out  1  reg write data: 1=MDR, 0=ALU result
//  jal       out  1  dest=$31, data=PC (jal only)
//  sext      out  1  1=sign-extend imm, 0=zero-extend
//  shift     out  1  ALU A = shamt (sll/srl/sra)
//  alusrca   out  1  ALU A: 0=PC, 1=reg A
//  alusrcb   out  2  ALU B: 00=reg B, 01=4, 10=ext imm, 11=ext imm<<2
//  aluc      out  4  ALU op code
//  pcsource  out  2  PC mux: 00=ALU, 01=ALU result reg (branch), 10=reg A (jr), 11=jump addr
//  illegal   out  1  undefined op/func decoded (1 in SID only)
//  state     out  3  current state (debug)
// BEHAVIOUR
//  - States: SIF=0, SID=1, SEXE=2, SMEM=3, SWB=4. Codes 5-7 unreachable; next state SIF.
//  - rdy = mready | ~MEM_WAIT.
//  - Outputs are combinational from state/op/func/z/rdy.
//  - All write enables (wpc, wir, wmem, wreg) are ANDed with clrn.
//  - Reset: clrn=0 forces state=SIF immediately; wpc=wir=wmem=wreg=0, illegal=0.
//  - Reset mid-instruction abandons the instruction; there is no partial writeback.
//  - SIF: iord=0, alusrca=0, alusrcb=01, aluc=ADD, pcsource=00, wir=wpc=rdy.
//    Next state: SID if rdy, else stay in SIF.
//  - SID: alusrca=0, alusrcb=11, aluc=ADD (branch target into ALU result reg).
//    - j: wpc=1, pcsource=11; next SIF.
//    - jal: also wreg=1, jal=1; next SIF.
//    - jr: wpc=1, pcsource=10; next SIF.
//    - illegal: illegal=1, no writes; next SIF.
//    - otherwise next SEXE.
//  - SEXE: alusrca=1.
//    - R-type: alusrcb=00. Shifts also set shift=1.
//    - I-type: alusrcb=10. sext=1 for addi/lw/sw/beq/bne; 0 for andi/ori/xori/lui.
//    - beq/bne: aluc=SUB, pcsource=01, wpc=(beq&z)|(bne&~z); next SIF.
//    - lw/sw: aluc=ADD; next SMEM.
//    - All others: next SWB.
//  - SMEM: iord=1.
//    - sw: wmem=rdy; next SIF on rdy, else hold.
//    - lw: next SWB on rdy, else hold. MDR captures every cycle.
//  - SWB: wreg=1, regrt=~Rtype, m2reg=lw; next SIF.
//  - Latency with rdy=1: R/I-ALU 4, lw 5, sw 4, beq/bne 3, j/jal/jr 2 cycles.
//  - Each stall cycle adds 1. wmem and wir are never asserted while rdy=0.
//  - A beq with z=1 and a bne with z=0 are mutually exclusive: exactly one wpc pulse or none.
//  - ALU codes: ADD=x000, SUB=x100, AND=x001, OR=x101, XOR=x010, LUI=x110,
//    SLL=0011, SRL=0111, SRA=1111. Don't-care bits are driven 0.
// STRUCTURE
//  - mc_defs.vh (shared `include): state codes, opcode/func constants, ALUC codes, alusrcb/pcsource encodings.
//  - Sub-module mc_decode: combinational op/func to one-hot instruction flags (i_add..i_jal, rtype, illegal).
//  - mc_ctrl_fsm holds the state register (async clrn) and the output decode.
// TESTING
//  1. clrn=0 mid-SEXE of add -> state=0 within same cycle, all write enables 0.
//     After release: first cycle wir=wpc=1 (mready=1).
//  2. add $3,$1,$2, mready=1 -> states 0,1,2,4,0.
//     In SWB: wreg=1, regrt=0, m2reg=0. Exactly 4 cycles.
//  3. lw with mready=0 for 2 cycles in SIF and 3 cycles in SMEM -> 10 cycles total.
//     wir only on the ready cycle; m2reg=1, regrt=1 in SWB.
//  4. beq with z=1 -> wpc=1, pcsource=01 in SEXE.
//     beq z=0 -> wpc=0. bne inverse. Both take 3 cycles.
//  5. jal -> in SID: wpc=1, pcsource=11, wreg=1, jal=1; back to SIF at cycle 2.
//     jr -> pcsource=10.
//  6. op=6'b111111 -> illegal=1 in SID, no write enables; next state SIF.
//     MEM_WAIT=0 with mready=0 -> lw still takes 5 cycles.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcode and
// func constants, ALU op codes, datapath mux encodings and decoded-flag struct.
package mc_ctrl_fsm_pkg;

   typedef enum logic [2:0] {
      SIF  = 3'd0,
      SID  = 3'd1,
      SEXE = 3'd2,
      SMEM = 3'd3,
      SWB  = 3'd4
   } state_e;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] F_SLL = 6'h00;
   localparam logic [5:0] F_SRL = 6'h02;
   localparam logic [5:0] F_SRA = 6'h03;
   localparam logic [5:0] F_JR  = 6'h08;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26;

   // ALU op codes; don't-care MSBs are tied to 0
   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;

   // ALU B operand select
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   // PC source select
   localparam logic [1:0] PCS_ALU = 2'b00;
   localparam logic [1:0] PCS_BR  = 2'b01;
   localparam logic [1:0] PCS_JR  = 2'b10;
   localparam logic [1:0] PCS_JMP = 2'b11;

   // One-hot instruction flags; rtype/illegal are summary bits (last two)
   typedef struct packed {
      logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
      logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne;
      logic i_j, i_jal;
      logic rtype;
      logic illegal;
   } insn_t;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational op/func decode into one-hot instruction flags.
module mc_ctrl_fsm_decode
   import mc_ctrl_fsm_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] func_i,
   output insn_t      ins_o
);

   logic is_r;
   assign is_r = (op_i == OP_RTYPE);

   // Flag decode; anything that matches no instruction is illegal
   always_comb begin
      ins_o        = '0;
      ins_o.i_add  = is_r && (func_i == F_ADD);
      ins_o.i_sub  = is_r && (func_i == F_SUB);
      ins_o.i_and  = is_r && (func_i == F_AND);
      ins_o.i_or   = is_r && (func_i == F_OR);
      ins_o.i_xor  = is_r && (func_i == F_XOR);
      ins_o.i_sll  = is_r && (func_i == F_SLL);
      ins_o.i_srl  = is_r && (func_i == F_SRL);
      ins_o.i_sra  = is_r && (func_i == F_SRA);
      ins_o.i_jr   = is_r && (func_i == F_JR);
      ins_o.i_addi = (op_i == OP_ADDI);
      ins_o.i_andi = (op_i == OP_ANDI);
      ins_o.i_ori  = (op_i == OP_ORI);
      ins_o.i_xori = (op_i == OP_XORI);
      ins_o.i_lui  = (op_i == OP_LUI);
      ins_o.i_lw   = (op_i == OP_LW);
      ins_o.i_sw   = (op_i == OP_SW);
      ins_o.i_beq  = (op_i == OP_BEQ);
      ins_o.i_bne  = (op_i == OP_BNE);
      ins_o.i_j    = (op_i == OP_J);
      ins_o.i_jal  = (op_i == OP_JAL);
      ins_o.rtype  = ins_o.i_add | ins_o.i_sub | ins_o.i_and | ins_o.i_or | ins_o.i_xor |
                     ins_o.i_sll | ins_o.i_srl | ins_o.i_sra | ins_o.i_jr;
      ins_o.illegal = (ins_o[$bits(insn_t)-1:2] == '0);
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control unit: sequences IF/ID/EXE/MEM/WB over the
// shared datapath and drives all write enables and mux selects.
module mc_ctrl_fsm
   import mc_ctrl_fsm_pkg::*;
#(
   parameter logic MEM_WAIT = 1'b1
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   input  logic       mready,
   output logic       wpc,
   output logic       wir,
   output logic       wmem,
   output logic       wreg,
   output logic       iord,
   output logic       regrt,
   output logic       m2reg,
   output logic       jal,
   output logic       sext,
   output logic       shift,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluc,
   output logic [1:0] pcsource,
   output logic       illegal,
   output logic [2:0] state
);

   state_e state_q, state_d;
   insn_t  ins;
   logic   rdy;
   logic   wpc_c, wir_c, wmem_c, wreg_c, illegal_c;

   assign rdy = mready | ~MEM_WAIT;

   mc_ctrl_fsm_decode u_dec (
      .op_i   (op),
      .func_i (func),
      .ins_o  (ins)
   );

   // State register; reset abandons any in-flight instruction
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_q <= SIF;
      else       state_q <= state_d;
   end

   // Next-state and output decode
   always_comb begin
      state_d   = SIF;
      wpc_c     = 1'b0;
      wir_c     = 1'b0;
      wmem_c    = 1'b0;
      wreg_c    = 1'b0;
      illegal_c = 1'b0;
      iord      = 1'b0;
      regrt     = 1'b0;
      m2reg     = 1'b0;
      jal       = 1'b0;
      sext      = 1'b0;
      shift     = 1'b0;
      alusrca   = 1'b0;
      alusrcb   = SRCB_REG;
      aluc      = ALUC_ADD;
      pcsource  = PCS_ALU;
      case (state_q)
         SIF: begin
            alusrcb = SRCB_FOUR;
            wir_c   = rdy;
            wpc_c   = rdy;
            state_d = rdy ? SID : SIF;
         end
         SID: begin
            // branch target computed here regardless of instruction
            alusrcb = SRCB_BR;
            state_d = SEXE;
            if (ins.i_j) begin
               wpc_c    = 1'b1;
               pcsource = PCS_JMP;
               state_d  = SIF;
            end else if (ins.i_jal) begin
               wpc_c    = 1'b1;
               pcsource = PCS_JMP;
               wreg_c   = 1'b1;
               jal      = 1'b1;
               state_d  = SIF;
            end else if (ins.i_jr) begin
               wpc_c    = 1'b1;
               pcsource = PCS_JR;
               state_d  = SIF;
            end else if (ins.illegal) begin
               illegal_c = 1'b1;
               state_d   = SIF;
            end
         end
         SEXE: begin
            alusrca = 1'b1;
            alusrcb = ins.rtype ? SRCB_REG : SRCB_IMM;
            shift   = ins.i_sll | ins.i_srl | ins.i_sra;
            sext    = ins.i_addi | ins.i_lw | ins.i_sw | ins.i_beq | ins.i_bne;
            if (ins.i_sub | ins.i_beq | ins.i_bne)  aluc = ALUC_SUB;
            else if (ins.i_and | ins.i_andi)        aluc = ALUC_AND;
            else if (ins.i_or | ins.i_ori)          aluc = ALUC_OR;
            else if (ins.i_xor | ins.i_xori)        aluc = ALUC_XOR;
            else if (ins.i_lui)                     aluc = ALUC_LUI;
            else if (ins.i_sll)                     aluc = ALUC_SLL;
            else if (ins.i_srl)                     aluc = ALUC_SRL;
            else if (ins.i_sra)                     aluc = ALUC_SRA;
            else                                    aluc = ALUC_ADD;
            if (ins.i_beq | ins.i_bne) begin
               pcsource = PCS_BR;
               wpc_c    = (ins.i_beq & z) | (ins.i_bne & ~z);
               state_d  = SIF;
            end else if (ins.i_lw | ins.i_sw) begin
               state_d  = SMEM;
            end else begin
               state_d  = SWB;
            end
         end
         SMEM: begin
            iord = 1'b1;
            if (ins.i_sw) begin
               wmem_c  = rdy;
               state_d = rdy ? SIF : SMEM;
            end else begin
               state_d = rdy ? SWB : SMEM;
            end
         end
         SWB: begin
            wreg_c  = 1'b1;
            regrt   = ~ins.rtype;
            m2reg   = ins.i_lw;
            state_d = SIF;
         end
         default: state_d = SIF;
      endcase
   end

   assign wpc     = wpc_c & clrn;
   assign wir     = wir_c & clrn;
   assign wmem    = wmem_c & clrn;
   assign wreg    = wreg_c & clrn;
   assign illegal = illegal_c & clrn;
   assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios then randomized instruction
// streams, checked against a stage-list model of each instruction class.
module tb_mc_ctrl_fsm;

   localparam int K_R = 0, K_SH = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                  K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  func;
      int          kind;
      logic [3:0]  aluc;
      logic        sext;
   } ent_t;

   typedef struct packed {
      logic       iord, regrt, m2reg, sext, shift, alusrca;
      logic [1:0] alusrcb;
      logic [3:0] aluc;
      logic [1:0] pcsource;
   } sel_t;

   logic       clk = 1'b0;
   logic       clrn;
   logic [5:0] op, func;
   logic       z, mready;

   logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca, illegal;
   logic [1:0] alusrcb, pcsource;
   logic [3:0] aluc;
   logic [2:0] state;

   logic       wpc0, wir0, wmem0, wreg0, iord0, regrt0, m2reg0, jal0, sext0, shift0, alusrca0, illegal0;
   logic [1:0] alusrcb0, pcsource0;
   logic [3:0] aluc0;
   logic [2:0] state0;

   int checks = 0;
   int failures = 0;
   ent_t tbl[$];

   mc_ctrl_fsm #(.MEM_WAIT(1'b1)) dut (
      .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mready(mready),
      .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
      .m2reg(m2reg), .jal(jal), .sext(sext), .shift(shift), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .illegal(illegal), .state(state)
   );

   mc_ctrl_fsm #(.MEM_WAIT(1'b0)) dut0 (
      .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mready(mready),
      .wpc(wpc0), .wir(wir0), .wmem(wmem0), .wreg(wreg0), .iord(iord0), .regrt(regrt0),
      .m2reg(m2reg0), .jal(jal0), .sext(sext0), .shift(shift0), .alusrca(alusrca0),
      .alusrcb(alusrcb0), .aluc(aluc0), .pcsource(pcsource0), .illegal(illegal0), .state(state0)
   );

   always #5 clk = ~clk;

   function automatic void add_ent(string n, logic [5:0] o, logic [5:0] f, int k,
                                   logic [3:0] a, logic s);
      ent_t e;
      e.name = n; e.op = o; e.func = f; e.kind = k; e.aluc = a; e.sext = s;
      tbl.push_back(e);
   endfunction

   function automatic int find(string n);
      foreach (tbl[i]) if (tbl[i].name == n) return i;
      return 0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply reset for one clock, checking outputs while it is held
   task automatic do_reset();
      clrn = 1'b0; mready = 1'b1; op = 6'h00; func = 6'h20; z = 1'b0;
      #1;
      chk("reset_state_we", {26'd0, state, wpc, wir, wmem}, 32'd0);
      chk("reset_wreg_ill", {30'd0, wreg, illegal}, 32'd0);
      @(posedge clk); #1;
      clrn = 1'b1;
   endtask

   // Run one instruction through the model: the stage list per class, with
   // IF/MEM stages held for n_if / n_mem not-ready cycles.
   task automatic run_insn(int e, logic zz, int n_if, int n_mem);
      int   stg[$];
      int   idx, s, k, sif, smem;
      logic rdy;
      logic ewpc, ewir, ewmem, ewreg, eill, ejal;
      sel_t ex, mk, ob;
      k = tbl[e].kind;
      case (k)
         K_R, K_SH, K_I: stg = '{0, 1, 2, 4};
         K_LW:           stg = '{0, 1, 2, 3, 4};
         K_SW:           stg = '{0, 1, 2, 3};
         K_BEQ, K_BNE:   stg = '{0, 1, 2};
         default:        stg = '{0, 1};
      endcase
      op = tbl[e].op; func = tbl[e].func; z = zz;
      idx = 0; sif = 0; smem = 0;
      while (idx < stg.size()) begin
         s = stg[idx];
         if (s == 0)      rdy = (sif >= n_if);
         else if (s == 3) rdy = (smem >= n_mem);
         else             rdy = 1'($urandom_range(0, 1));
         mready = rdy;
         @(negedge clk);
         ewir  = (s == 0) && rdy;
         ewpc  = ((s == 0) && rdy) || ((s == 1) && (k == K_J || k == K_JAL || k == K_JR)) ||
                 ((s == 2) && ((k == K_BEQ && zz) || (k == K_BNE && !zz)));
         ewmem = (s == 3) && (k == K_SW) && rdy;
         ewreg = (s == 4) || ((s == 1) && (k == K_JAL));
         eill  = (s == 1) && (k == K_ILL);
         ejal  = (s == 1) && (k == K_JAL);
         chk($sformatf("%s_s%0d_ctl", tbl[e].name, s),
             {23'd0, state, wpc, wir, wmem, wreg, illegal, jal},
             {23'd0, 3'(s), ewpc, ewir, ewmem, ewreg, eill, ejal});
         ex = '0; mk = '0;
         case (s)
            0: begin
               mk.iord = 1; mk.alusrca = 1; mk.alusrcb = '1; mk.aluc = '1; mk.pcsource = '1;
               ex.alusrcb = 2'b01;
            end
            1: begin
               mk.alusrca = 1; mk.alusrcb = '1; mk.aluc = '1;
               ex.alusrcb = 2'b11;
               if (k == K_J || k == K_JAL) begin mk.pcsource = '1; ex.pcsource = 2'b11; end
               if (k == K_JR)              begin mk.pcsource = '1; ex.pcsource = 2'b10; end
            end
            2: begin
               mk.alusrca = 1; mk.alusrcb = '1; mk.aluc = '1; mk.shift = 1;
               ex.alusrca = 1;
               ex.alusrcb = (k == K_R || k == K_SH) ? 2'b00 : 2'b10;
               ex.aluc    = tbl[e].aluc;
               ex.shift   = (k == K_SH);
               if (k != K_R && k != K_SH) begin mk.sext = 1; ex.sext = tbl[e].sext; end
               if (k == K_BEQ || k == K_BNE) begin mk.pcsource = '1; ex.pcsource = 2'b01; end
            end
            3: begin mk.iord = 1; ex.iord = 1; end
            default: begin
               mk.regrt = 1; mk.m2reg = 1;
               ex.regrt = (k != K_R && k != K_SH);
               ex.m2reg = (k == K_LW);
            end
         endcase
         ob = {iord, regrt, m2reg, sext, shift, alusrca, alusrcb, aluc, pcsource};
         chk($sformatf("%s_s%0d_sel", tbl[e].name, s), {18'd0, ob & mk}, {18'd0, ex & mk});
         if (s == 0)      begin if (rdy) idx++; else sif++;  end
         else if (s == 3) begin if (rdy) idx++; else smem++; end
         else             idx++;
         @(posedge clk); #1;
      end
      chk($sformatf("%s_ret_sif", tbl[e].name), {29'd0, state}, 32'd0);
   endtask

   initial begin
      int e;
      add_ent("add",  6'h00, 6'h20, K_R,   4'b0000, 1'b0);
      add_ent("sub",  6'h00, 6'h22, K_R,   4'b0100, 1'b0);
      add_ent("and",  6'h00, 6'h24, K_R,   4'b0001, 1'b0);
      add_ent("or",   6'h00, 6'h25, K_R,   4'b0101, 1'b0);
      add_ent("xor",  6'h00, 6'h26, K_R,   4'b0010, 1'b0);
      add_ent("sll",  6'h00, 6'h00, K_SH,  4'b0011, 1'b0);
      add_ent("srl",  6'h00, 6'h02, K_SH,  4'b0111, 1'b0);
      add_ent("sra",  6'h00, 6'h03, K_SH,  4'b1111, 1'b0);
      add_ent("jr",   6'h00, 6'h08, K_JR,  4'b0000, 1'b0);
      add_ent("addi", 6'h08, 6'h15, K_I,   4'b0000, 1'b1);
      add_ent("andi", 6'h0c, 6'h2a, K_I,   4'b0001, 1'b0);
      add_ent("ori",  6'h0d, 6'h01, K_I,   4'b0101, 1'b0);
      add_ent("xori", 6'h0e, 6'h3c, K_I,   4'b0010, 1'b0);
      add_ent("lui",  6'h0f, 6'h00, K_I,   4'b0110, 1'b0);
      add_ent("lw",   6'h23, 6'h04, K_LW,  4'b0000, 1'b1);
      add_ent("sw",   6'h2b, 6'h10, K_SW,  4'b0000, 1'b1);
      add_ent("beq",  6'h04, 6'h3f, K_BEQ, 4'b0100, 1'b1);
      add_ent("bne",  6'h05, 6'h02, K_BNE, 4'b0100, 1'b1);
      add_ent("j",    6'h02, 6'h20, K_J,   4'b0000, 1'b0);
      add_ent("jal",  6'h03, 6'h08, K_JAL, 4'b0000, 1'b0);
      add_ent("ill",  6'h3f, 6'h20, K_ILL, 4'b0000, 1'b0);
      add_ent("rbad", 6'h00, 6'h01, K_ILL, 4'b0000, 1'b0);

      do_reset();

      // Reset asserted mid-SEXE of add; restart fetches immediately after release
      op = 6'h00; func = 6'h20; mready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midexe_state", {29'd0, state}, 32'd2);
      clrn = 1'b0;
      #1;
      chk("midexe_rst", {25'd0, state, wpc, wir, wmem, wreg}, 32'd0);
      @(posedge clk); #1;
      clrn = 1'b1;
      run_insn(find("add"), 1'b0, 0, 0);

      // Directed instructions and stall patterns
      run_insn(find("lw"),  1'b0, 2, 3);
      run_insn(find("beq"), 1'b1, 0, 0);
      run_insn(find("beq"), 1'b0, 0, 0);
      run_insn(find("bne"), 1'b1, 0, 0);
      run_insn(find("bne"), 1'b0, 0, 0);
      run_insn(find("jal"), 1'b0, 0, 0);
      run_insn(find("jr"),  1'b0, 0, 0);
      run_insn(find("ill"), 1'b0, 0, 0);
      run_insn(find("rbad"), 1'b1, 1, 0);
      run_insn(find("sw"),  1'b0, 1, 2);

      // MEM_WAIT=0 ignores mready: lw runs 5 cycles with mready held low
      do_reset();
      op = 6'h23; func = 6'h00; mready = 1'b0; z = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("nowait_lw_c%0d", c), {28'd0, state0, wmem0 | wir0},
             {28'd0, 3'(c), (c == 0) || (c == 3) ? 1'b0 : 1'b0} | ((c == 0) ? 32'd1 : 32'd0));
         @(posedge clk); #1;
      end
      chk("nowait_lw_ret", {29'd0, state0}, 32'd0);

      // Randomized instruction stream with random stall lengths
      do_reset();
      for (int n = 0; n < 80; n++) begin
         e = int'($urandom_range(0, tbl.size() - 1));
         run_insn(e, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
